move_scheduler: RTL and testbench
=================================

# move_scheduler

Per-frame movement sequencer for up to NUM_OBJ on-screen objects (player and enemy tanks). On each startOfFrame it walks the objects in index order, computes each object's candidate position from its 4-bit direction keys, and shares a single external collision checker among them through a req/done handshake. It commits each candidate only when the checker reports no hit, and drives the resulting top-left pixel coordinates to the object drawers.

## Interface
Parameters:
- NUM_OBJ, 4: number of objects sequenced; 1..8.
- MOVE_SPEED, 20: sub-pixel step per frame per axis (units of 1/64 pixel).
- INIT_X, 280: reset pixel X of object 0.
- INIT_Y, 185: reset pixel Y of all objects.
- OBJ_SPACING, 64: reset pixel X offset between consecutive objects.
- CHK_TIMEOUT, 255: maximum CHECK cycles before forcing a hit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- dirKeys  in  4*NUM_OBJ  object i keys at [4i+3:4i]. Bit 0 = +Y, bit 1 = -Y, bit 2 = -X, bit 3 = +X.
- chkReq  out  1  collision check request.
- chkId  out  3  index of object under check.
- chkX, chkY  out  11 each  candidate top-left pixel.
- chkDone  in  1  checker response valid.
- chkHit  in  1  candidate collides; valid with chkDone.
- topLeftX, topLeftY  out  11*NUM_OBJ each  committed pixel positions, object i at [11i+10:11i].
- busy  out  1  sequence in progress.
- frameOverrun  out  1  one-cycle pulse when startOfFrame arrives while busy.

## Operation
- Positions are held internally as unsigned sub-pixel values (pixel*64). Output = internal >> 6.
- Per-axis speed is derived from the keys:
  - X axis: bit2 XOR bit3 gives -MOVE_SPEED if bit2 is set, +MOVE_SPEED if bit3 is set; otherwise 0.
  - Y axis: the same rule applies with bit0 (+) and bit1 (-).
- FSM states: IDLE, CALC, CHECK, COMMIT.
  - IDLE: on startOfFrame, go to CALC with idx=0.
  - CALC: sample dirKeys for obj idx and register the candidate.
    - Both speeds zero: go to COMMIT with hit=1. The position is unchanged and no request is issued.
    - Candidate out of range (X outside 0..639*64 or Y outside 0..479*64, including arithmetic underflow): go to COMMIT with hit=1 and no request.
    - Otherwise: go to CHECK.
  - CHECK: chkReq=1, with chkId/chkX/chkY held stable. Exit to COMMIT in the cycle after chkDone is sampled high, latching chkHit. If CHK_TIMEOUT cycles elapse without chkDone, set hit=1 and exit.
  - COMMIT: if !hit, position[idx] <= candidate. Then, if idx==NUM_OBJ-1, go to IDLE; else idx++ and go to CALC.
- X and Y move together. There is no per-axis partial commit.
- chkDone while chkReq=0 is ignored.
- startOfFrame while busy is ignored and pulses frameOverrun. The current sequence continues.

## Timing
- Reset values:
  - positions: X = INIT_X + i*OBJ_SPACING, Y = INIT_Y.
  - chkReq=0, chkId=0, chkX=chkY=0, busy=0, frameOverrun=0.
  - state=IDLE.
- Reset asserted mid-sequence aborts it immediately, returning to the reset values, including positions.
- Object timing:
  - Stationary or out-of-range object: 2 cycles (CALC, COMMIT).
  - Checked object: 2 + N cycles, where N = CHECK cycles including the chkDone cycle.
- Edge-by-edge sequence:
  - startOfFrame high at edge t: busy=1 and state=CALC from t.
  - chkReq rises at the edge after CALC.
  - chkReq falls at the edge following the chkDone sample.
  - topLeft of obj idx updates at the COMMIT edge.
  - busy falls at the edge leaving the last COMMIT.
- Sequence length:
  - Minimum: 2*NUM_OBJ cycles.
  - Worst case: NUM_OBJ*(2+CHK_TIMEOUT) cycles. This must be below the frame period.

## Structure
- move_sched_pkg holds:
  - MULTIPLIER=64 and SHIFT=6.
  - X_MAX=639*64 and Y_MAX=479*64.
  - Key bit index constants KEY_DOWN=0, KEY_UP=1, KEY_LEFT=2, KEY_RIGHT=3.
  - The typedef enum for the FSM states.
- Sub-module move_step_calc (combinational): takes keys, position X/Y and MOVE_SPEED. Produces candidate X/Y, a moving flag, and an out-of-range flag.
- Top level: FSM, idx counter, timeout counter, position register file, output unpacking.

## Test plan
- Reset release, no keys, four startOfFrame pulses:
  - busy high exactly 8 cycles per frame.
  - chkReq never asserted.
  - Obj0 stays at (280,185); obj3 stays at (472,185).
- Obj0 keys=4'b1000 for 64 frames, checker replies done, hit=0 after 3 cycles: obj0 X steps 280 -> 300, i.e. 20*64/64.
- Obj1 keys=4'b0001, checker hit=1 on every request: obj1 Y stays at 185, and chkId=1 is seen each frame.
- Obj2 keys=4'b0010 with Y driven toward 0: clamps at Y=0, and no request is issued once the candidate goes negative.
- Checker never responds:
  - chkReq held for exactly 255 cycles per moving object.
  - Position unchanged.
  - A startOfFrame during the sequence pulses frameOverrun once.
- Reset asserted during CHECK of obj2: chkReq drops immediately and all positions return to their reset values.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared constants and types for the per-frame movement sequencer.
package move_sched_pkg;

    // Positions are kept in 1/64 pixel units
    localparam int MULTIPLIER = 64;
    localparam int SHIFT      = 6;

    // Largest legal sub-pixel top-left coordinates
    localparam int X_MAX = 639 * 64;
    localparam int Y_MAX = 479 * 64;

    // Bit positions inside one object's 4-bit key nibble
    localparam int KEY_DOWN  = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/move_scheduler_if.sv
// Request/response handshake between the scheduler and the shared collision checker.
interface move_scheduler_if;
    logic        chkReq;
    logic [2:0]  chkId;
    logic [10:0] chkX;
    logic [10:0] chkY;
    logic        chkDone;
    logic        chkHit;

    modport master (output chkReq, chkId, chkX, chkY, input chkDone, chkHit);
    modport slave  (input chkReq, chkId, chkX, chkY, output chkDone, chkHit);
endinterface

// File: rtl/move_scheduler_step_calc.sv
// Combinational candidate-position calculator for one object.
module move_step_calc
    import move_sched_pkg::*;
#(
    parameter int MOVE_SPEED = 20
)
(
    input  logic [3:0]  i_keys,
    input  logic [15:0] i_pos_x,
    input  logic [15:0] i_pos_y,
    output logic [15:0] o_cand_x,
    output logic [15:0] o_cand_y,
    output logic        o_moving,
    output logic        o_out_of_range
);

    localparam logic signed [17:0] SPD    = 18'(MOVE_SPEED);
    localparam logic signed [17:0] XMAX_S = 18'(X_MAX);
    localparam logic signed [17:0] YMAX_S = 18'(Y_MAX);

    logic signed [17:0] w_spd_x;
    logic signed [17:0] w_spd_y;
    logic signed [17:0] w_sum_x;
    logic signed [17:0] w_sum_y;

    // Derive per-axis speed from the keys and range-check the signed candidate
    always_comb begin
        w_spd_x = 18'sd0;
        w_spd_y = 18'sd0;
        if (i_keys[KEY_LEFT] ^ i_keys[KEY_RIGHT]) begin
            w_spd_x = i_keys[KEY_LEFT] ? -SPD : SPD;
        end else begin
            w_spd_x = 18'sd0;
        end
        if (i_keys[KEY_DOWN] ^ i_keys[KEY_UP]) begin
            w_spd_y = i_keys[KEY_UP] ? -SPD : SPD;
        end else begin
            w_spd_y = 18'sd0;
        end
        // Two extra bits keep underflow visible as a negative value
        w_sum_x        = $signed({2'b00, i_pos_x}) + w_spd_x;
        w_sum_y        = $signed({2'b00, i_pos_y}) + w_spd_y;
        o_moving       = (w_spd_x != 18'sd0) || (w_spd_y != 18'sd0);
        o_out_of_range = (w_sum_x < 18'sd0) || (w_sum_x > XMAX_S) ||
                         (w_sum_y < 18'sd0) || (w_sum_y > YMAX_S);
        o_cand_x       = w_sum_x[15:0];
        o_cand_y       = w_sum_y[15:0];
    end

endmodule

// File: rtl/move_scheduler.sv
// Per-frame movement sequencer: walks objects in order, checks each moving
// candidate with a shared collision checker and commits collision-free moves.
module move_scheduler
    import move_sched_pkg::*;
#(
    parameter int NUM_OBJ     = 4,
    parameter int MOVE_SPEED  = 20,
    parameter int INIT_X      = 280,
    parameter int INIT_Y      = 185,
    parameter int OBJ_SPACING = 64,
    parameter int CHK_TIMEOUT = 255
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [4*NUM_OBJ-1:0]   dirKeys,
    move_scheduler_if.master       chk,
    output logic [11*NUM_OBJ-1:0]  topLeftX,
    output logic [11*NUM_OBJ-1:0]  topLeftY,
    output logic                   busy,
    output logic                   frameOverrun
);

    localparam int TMO_W = $clog2(CHK_TIMEOUT + 1);

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_hit;
    logic [15:0]        r_cand_x;
    logic [15:0]        r_cand_y;
    logic [15:0]        r_pos_x [NUM_OBJ];
    logic [15:0]        r_pos_y [NUM_OBJ];
    logic               r_chk_req;
    logic [2:0]         r_chk_id;
    logic [10:0]        r_chk_x;
    logic [10:0]        r_chk_y;
    logic               r_busy;
    logic               r_overrun;

    logic [3:0]         w_keys;
    logic [15:0]        w_cur_x;
    logic [15:0]        w_cur_y;
    logic [15:0]        w_cand_x;
    logic [15:0]        w_cand_y;
    logic               w_moving;
    logic               w_oor;

    // Select the keys and current position of the object being sequenced
    always_comb begin
        w_keys  = 4'b0000;
        w_cur_x = 16'd0;
        w_cur_y = 16'd0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_keys  = w_keys  | ((r_idx == 3'(i)) ? dirKeys[4*i +: 4] : 4'b0000);
            w_cur_x = w_cur_x | ((r_idx == 3'(i)) ? r_pos_x[i] : 16'd0);
            w_cur_y = w_cur_y | ((r_idx == 3'(i)) ? r_pos_y[i] : 16'd0);
        end
    end

    move_step_calc #(
        .MOVE_SPEED (MOVE_SPEED)
    ) u_step_calc (
        .i_keys         (w_keys),
        .i_pos_x        (w_cur_x),
        .i_pos_y        (w_cur_y),
        .o_cand_x       (w_cand_x),
        .o_cand_y       (w_cand_y),
        .o_moving       (w_moving),
        .o_out_of_range (w_oor)
    );

    // Sequencer FSM, checker handshake, timeout counter and position file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= 3'd0;
            r_tmo     <= '0;
            r_hit     <= 1'b0;
            r_cand_x  <= 16'd0;
            r_cand_y  <= 16'd0;
            r_chk_req <= 1'b0;
            r_chk_id  <= 3'd0;
            r_chk_x   <= 11'd0;
            r_chk_y   <= 11'd0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_pos_x[i] <= 16'((INIT_X + i * OBJ_SPACING) * MULTIPLIER);
                r_pos_y[i] <= 16'(INIT_Y * MULTIPLIER);
            end
        end else begin
            // A frame start that lands mid-sequence is dropped but flagged
            r_overrun <= startOfFrame & r_busy;
            case (r_state)
                IDLE: begin
                    if (startOfFrame) begin
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                CALC: begin
                    r_cand_x <= w_cand_x;
                    r_cand_y <= w_cand_y;
                    if (!w_moving || w_oor) begin
                        // Nothing worth checking: treat as blocked, position kept
                        r_hit   <= 1'b1;
                        r_state <= COMMIT;
                    end else begin
                        r_hit     <= 1'b0;
                        r_tmo     <= '0;
                        r_chk_req <= 1'b1;
                        r_chk_id  <= r_idx;
                        r_chk_x   <= 11'(w_cand_x >> SHIFT);
                        r_chk_y   <= 11'(w_cand_y >> SHIFT);
                        r_state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk.chkDone) begin
                        r_hit     <= chk.chkHit;
                        r_chk_req <= 1'b0;
                        r_state   <= COMMIT;
                    end else if (r_tmo == TMO_W'(CHK_TIMEOUT - 1)) begin
                        // Silent checker: block the move rather than stall the frame
                        r_hit     <= 1'b1;
                        r_chk_req <= 1'b0;
                        r_state   <= COMMIT;
                    end else begin
                        r_tmo     <= r_tmo + TMO_W'(1);
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        if (!r_hit && (r_idx == 3'(i))) begin
                            r_pos_x[i] <= r_cand_x;
                            r_pos_y[i] <= r_cand_y;
                        end else begin
                            r_pos_x[i] <= r_pos_x[i];
                            r_pos_y[i] <= r_pos_y[i];
                        end
                    end
                    if (r_idx == 3'(NUM_OBJ - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= CALC;
                    end
                end
                default: begin
                    r_chk_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign chk.chkReq   = r_chk_req;
    assign chk.chkId    = r_chk_id;
    assign chk.chkX     = r_chk_x;
    assign chk.chkY     = r_chk_y;
    assign busy         = r_busy;
    assign frameOverrun = r_overrun;

    // Present committed positions as whole pixels
    always_comb begin
        topLeftX = '0;
        topLeftY = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            topLeftX[11*i +: 11] = 11'(r_pos_x[i] >> SHIFT);
            topLeftY[11*i +: 11] = 11'(r_pos_y[i] >> SHIFT);
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed self-checking bench for move_scheduler with a behavioural checker responder.
module tb_move_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [15:0] dirKeys;
    logic [43:0] topLeftX;
    logic [43:0] topLeftY;
    logic        busy;
    logic        frameOverrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder configuration
    int   rsp_delay = 3;
    logic rsp_hit   = 1'b0;
    logic rsp_never = 1'b0;
    int   rsp_cnt   = 0;

    move_scheduler_if chk ();

    move_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .dirKeys      (dirKeys),
        .chk          (chk),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .busy         (busy),
        .frameOverrun (frameOverrun)
    );

    always #5 clk = ~clk;

    // Collision checker model: answers on the rsp_delay-th request cycle
    always @(negedge clk) begin
        if (chk.chkReq && !rsp_never) begin
            rsp_cnt     = rsp_cnt + 1;
            chk.chkDone = (rsp_cnt == rsp_delay);
            chk.chkHit  = rsp_hit;
        end else begin
            rsp_cnt     = 0;
            chk.chkDone = 1'b0;
            chk.chkHit  = 1'b0;
        end
    end

    function automatic logic [10:0] px_x(input int i);
        return topLeftX[11*i +: 11];
    endfunction

    function automatic logic [10:0] px_y(input int i);
        return topLeftY[11*i +: 11];
    endfunction

    // Pulse startOfFrame, then observe the sequence until busy drops
    task automatic run_frame(input int sof2_at, output int busy_cyc, output int req_cyc,
                             output int ovr_cnt, output logic [7:0] ids,
                             output logic [10:0] last_x, output logic [10:0] last_y);
        int guard;
        busy_cyc = 0; req_cyc = 0; ovr_cnt = 0; ids = 8'd0;
        last_x = 11'd0; last_y = 11'd0; guard = 0;
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        while (busy && guard < 5000) begin
            busy_cyc++;
            if (chk.chkReq) begin
                req_cyc++;
                ids[chk.chkId] = 1'b1;
                last_x = chk.chkX;
                last_y = chk.chkY;
            end
            if (frameOverrun) ovr_cnt++;
            startOfFrame = (busy_cyc == sof2_at);
            @(negedge clk);
            guard++;
        end
        if (frameOverrun) ovr_cnt++;
        startOfFrame = 1'b0;
        n_checks++;
        if (guard >= 5000) begin
            n_fail++;
            $display("FAIL frame_timeout: busy still high after %0d cycles, required below 5000", guard);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; startOfFrame = 1'b0; dirKeys = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (chk.chkReq !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", chk.chkReq); end
        n_checks++; if (chk.chkId !== 3'd0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", chk.chkId); end
        n_checks++; if (chk.chkX !== 11'd0 || chk.chkY !== 11'd0) begin n_fail++; $display("FAIL rst_chkxy: got %0d,%0d want 0,0", chk.chkX, chk.chkY); end
        n_checks++; if (frameOverrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b want 0", frameOverrun); end
        n_checks++; if (topLeftX !== {11'd472, 11'd408, 11'd344, 11'd280}) begin n_fail++; $display("FAIL rst_x: got %h want %h", topLeftX, {11'd472, 11'd408, 11'd344, 11'd280}); end
        n_checks++; if (topLeftY !== {4{11'd185}}) begin n_fail++; $display("FAIL rst_y: got %h want %h", topLeftY, {4{11'd185}}); end
    endtask

    task automatic test_idle_frames();
        int b, r, o; logic [7:0] ids; logic [10:0] lx, ly;
        dirKeys = 16'h0000;
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, b, r, o, ids, lx, ly);
            n_checks++; if (b != 8) begin n_fail++; $display("FAIL idle_busy: frame %0d got %0d want 8", f, b); end
            n_checks++; if (r != 0) begin n_fail++; $display("FAIL idle_req: frame %0d got %0d want 0", f, r); end
        end
        n_checks++; if (px_x(0) !== 11'd280 || px_y(0) !== 11'd185) begin n_fail++; $display("FAIL idle_obj0: got %0d,%0d want 280,185", px_x(0), px_y(0)); end
        n_checks++; if (px_x(3) !== 11'd472 || px_y(3) !== 11'd185) begin n_fail++; $display("FAIL idle_obj3: got %0d,%0d want 472,185", px_x(3), px_y(3)); end
    endtask

    task automatic test_move_right();
        int b, r, o; logic [7:0] ids; logic [10:0] lx, ly;
        dirKeys = 16'h0008; rsp_delay = 3; rsp_hit = 1'b0; rsp_never = 1'b0;
        run_frame(-1, b, r, o, ids, lx, ly);
        n_checks++; if (b != 11) begin n_fail++; $display("FAIL right_busy: got %0d want 11", b); end
        n_checks++; if (r != 3) begin n_fail++; $display("FAIL right_req: got %0d want 3", r); end
        n_checks++; if (lx !== 11'd280 || ly !== 11'd185) begin n_fail++; $display("FAIL right_chkxy: got %0d,%0d want 280,185", lx, ly); end
        n_checks++; if (px_x(0) !== 11'd280) begin n_fail++; $display("FAIL right_f1: got %0d want 280", px_x(0)); end
        for (int f = 2; f <= 4; f++) run_frame(-1, b, r, o, ids, lx, ly);
        n_checks++; if (px_x(0) !== 11'd281) begin n_fail++; $display("FAIL right_f4: got %0d want 281", px_x(0)); end
        for (int f = 5; f <= 64; f++) run_frame(-1, b, r, o, ids, lx, ly);
        n_checks++; if (px_x(0) !== 11'd300 || px_y(0) !== 11'd185) begin n_fail++; $display("FAIL right_f64: got %0d,%0d want 300,185", px_x(0), px_y(0)); end
        n_checks++; if (px_x(1) !== 11'd344 || px_x(3) !== 11'd472) begin n_fail++; $display("FAIL right_others: got %0d,%0d want 344,472", px_x(1), px_x(3)); end
    endtask

    task automatic test_hit();
        int b, r, o; logic [7:0] ids; logic [10:0] lx, ly;
        dirKeys = 16'h0010; rsp_delay = 3; rsp_hit = 1'b1;
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, b, r, o, ids, lx, ly);
            n_checks++; if (ids !== 8'b0000_0010) begin n_fail++; $display("FAIL hit_ids: frame %0d got %b want 00000010", f, ids); end
            n_checks++; if (b != 11) begin n_fail++; $display("FAIL hit_busy: frame %0d got %0d want 11", f, b); end
        end
        n_checks++; if (px_y(1) !== 11'd185) begin n_fail++; $display("FAIL hit_y: got %0d want 185", px_y(1)); end
    endtask

    task automatic test_clamp();
        int b, r, o; logic [7:0] ids; logic [10:0] lx, ly;
        dirKeys = 16'h0200; rsp_delay = 1; rsp_hit = 1'b0;
        // 185*64 = 11840 sub-pixels, 592 steps of 20 reach exactly 0
        for (int f = 1; f <= 591; f++) run_frame(-1, b, r, o, ids, lx, ly);
        run_frame(-1, b, r, o, ids, lx, ly);
        n_checks++; if (r != 1 || ids !== 8'b0000_0100) begin n_fail++; $display("FAIL clamp_last_req: got req %0d ids %b want 1 00000100", r, ids); end
        n_checks++; if (ly !== 11'd0) begin n_fail++; $display("FAIL clamp_chky: got %0d want 0", ly); end
        run_frame(-1, b, r, o, ids, lx, ly);
        n_checks++; if (r != 0) begin n_fail++; $display("FAIL clamp_noreq: got %0d want 0", r); end
        n_checks++; if (b != 8) begin n_fail++; $display("FAIL clamp_busy: got %0d want 8", b); end
        n_checks++; if (px_y(2) !== 11'd0) begin n_fail++; $display("FAIL clamp_y: got %0d want 0", px_y(2)); end
    endtask

    task automatic test_timeout();
        int b, r, o; logic [7:0] ids; logic [10:0] lx, ly;
        dirKeys = 16'h4008; rsp_never = 1'b1;
        run_frame(50, b, r, o, ids, lx, ly);
        n_checks++; if (r != 510) begin n_fail++; $display("FAIL tmo_req: got %0d want 510", r); end
        n_checks++; if (b != 518) begin n_fail++; $display("FAIL tmo_busy: got %0d want 518", b); end
        n_checks++; if (o != 1) begin n_fail++; $display("FAIL tmo_overrun: got %0d want 1", o); end
        n_checks++; if (px_x(0) !== 11'd300 || px_x(3) !== 11'd472) begin n_fail++; $display("FAIL tmo_pos: got %0d,%0d want 300,472", px_x(0), px_x(3)); end
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_check();
        int guard, b, r, o; logic [7:0] ids; logic [10:0] lx, ly;
        dirKeys = 16'h0100; rsp_never = 1'b1; guard = 0;
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        while (!(chk.chkReq && chk.chkId == 3'd2) && guard < 2000) begin
            @(negedge clk); guard++;
        end
        n_checks++; if (guard >= 2000) begin n_fail++; $display("FAIL mid_wait: no obj2 request after %0d cycles", guard); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (chk.chkReq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_req: got req %b busy %b want 0 0", chk.chkReq, busy); end
        n_checks++; if (topLeftX !== {11'd472, 11'd408, 11'd344, 11'd280}) begin n_fail++; $display("FAIL mid_x: got %h want %h", topLeftX, {11'd472, 11'd408, 11'd344, 11'd280}); end
        n_checks++; if (topLeftY !== {4{11'd185}}) begin n_fail++; $display("FAIL mid_y: got %h want %h", topLeftY, {4{11'd185}}); end
        @(negedge clk); reset = 1'b0; dirKeys = 16'h0000; rsp_never = 1'b0;
        run_frame(-1, b, r, o, ids, lx, ly);
        n_checks++; if (b != 8) begin n_fail++; $display("FAIL mid_after: got %0d want 8", b); end
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_move_right();
        test_hit();
        test_clamp();
        test_timeout();
        test_reset_mid_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
